// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory read port plus dispatcher-facing head/pop signals.
// master = the fetch queue itself; slave = the environment (imem + dispatcher).
interface ifetch_queue_if;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_data;
  logic        dispatch_ren;
  logic        dispatch_jump_branch;
  logic [31:0] dispatch_jmp_branch_addr;
  logic [31:0] ifetch_instruction;
  logic [31:0] ifetch_pc_plus_four;
  logic        ifetch_empty_flag;
  logic        ifetch_full_flag;

  modport master (
    output imem_addr, imem_rd_en, ifetch_instruction, ifetch_pc_plus_four,
           ifetch_empty_flag, ifetch_full_flag,
    input  imem_data, dispatch_ren, dispatch_jump_branch, dispatch_jmp_branch_addr
  );

  modport slave (
    input  imem_addr, imem_rd_en, ifetch_instruction, ifetch_pc_plus_four,
           ifetch_empty_flag, ifetch_full_flag,
    output imem_data, dispatch_ren, dispatch_jump_branch, dispatch_jmp_branch_addr
  );
endinterface

// File: rtl/ifetch_queue.sv
// Sequential fetch + FWFT {instr, PC+4} queue feeding the dispatcher; redirect flushes everything.
// Optional IFQ_BYPASS_EN: head shows the returning imem word directly when the queue is empty.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  ifetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   ppf_q   [DEPTH];
  logic [31:0]   pc, issue_pc;
  logic          inflight;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  logic [CW:0]   occ;
  logic          flush, q_empty, bypass, empty, pop, q_pop, fill, wr_en, issue;

  assign flush   = bus.dispatch_jump_branch;
  assign q_empty = (count == '0);

  always_comb begin
    bypass = 1'b0;
`ifdef IFQ_BYPASS_EN
    // Keyed on inflight only so the head never depends combinationally on the redirect input.
    bypass = q_empty && inflight;
`endif
  end

  assign empty = q_empty && !bypass;
  assign pop   = bus.dispatch_ren && !empty;
  assign q_pop = pop && !q_empty;
  assign fill  = inflight && !flush;
  // A bypassed word that is popped the same cycle never lands in the array.
  assign wr_en = fill && !(bypass && pop);

  // Occupancy the queue will have once the outstanding read lands, net of this cycle's pop.
  assign occ        = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue      = !rst && !flush && (occ < (CW+1)'(DEPTH));
  assign count_next = count + CW'(wr_en) - CW'(q_pop);

  assign bus.imem_addr         = pc;
  assign bus.imem_rd_en        = issue;
  assign bus.ifetch_empty_flag = empty;
  assign bus.ifetch_full_flag  = (count == CW'(DEPTH));

  always_comb begin
    bus.ifetch_instruction  = 32'h0;
    bus.ifetch_pc_plus_four = 32'h0;
    if (bypass) begin
      bus.ifetch_instruction  = bus.imem_data;
      bus.ifetch_pc_plus_four = issue_pc + 32'd4;
    end else if (!q_empty) begin
      bus.ifetch_instruction  = instr_q[rd_ptr];
      bus.ifetch_pc_plus_four = ppf_q[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      issue_pc <= RESET_PC;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (flush) begin
      pc       <= bus.dispatch_jmp_branch_addr;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        pc       <= pc + 32'd4;
        issue_pc <= pc;
      end
      inflight <= issue;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (q_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_q[wr_ptr] <= bus.imem_data;
      ppf_q[wr_ptr]   <= issue_pc + 32'd4;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (DEPTH=4): fill, streaming pops, redirects, empty pop, async reset.
module tb_ifetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_iss;
  logic [31:0] exp_addr, exp_ppf;

  ifetch_queue_if bus();

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0:   word = 32'h00A0_0093;
      32'h4:   word = 32'h0010_0113;
      default: word = 32'hC0DE_0000 | a;
    endcase
  endfunction

  // 1-cycle synchronous instruction memory
  always @(posedge clk) if (bus.imem_rd_en) bus.imem_data <= word(bus.imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dispatch_ren             = 1'b0;
    bus.dispatch_jump_branch     = 1'b0;
    bus.dispatch_jmp_branch_addr = 32'h0;

    // reset state
    tick(); tick(); #1;
    chk("rst_rden",  32'(bus.imem_rd_en), 32'd0);
    chk("rst_empty", 32'(bus.ifetch_empty_flag), 32'd1);
    chk("rst_full",  32'(bus.ifetch_full_flag), 32'd0);
    chk("rst_instr", bus.ifetch_instruction, 32'h0);
    chk("rst_ppf",   bus.ifetch_pc_plus_four, 32'h0);

    // fill from reset with no pops: exactly 4 issues 0x0..0xC, then full
    tick(); rst = 1'b0;
    exp_addr = 32'h0; n_iss = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.imem_rd_en) begin
        chk("fill_addr", bus.imem_addr, exp_addr);
        exp_addr += 32'd4;
        n_iss++;
      end
      tick();
    end
    #1;
    chk("fill_nissue", 32'(n_iss), 32'd4);
    chk("fill_full",   32'(bus.ifetch_full_flag), 32'd1);
    chk("fill_empty",  32'(bus.ifetch_empty_flag), 32'd0);
    chk("fill_rden",   32'(bus.imem_rd_en), 32'd0);
    chk("fill_instr",  bus.ifetch_instruction, 32'h00A0_0093);
    chk("fill_ppf",    bus.ifetch_pc_plus_four, 32'h4);

    // streaming pops across pointer wrap: contiguous PC+4 sequence
    bus.dispatch_ren = 1'b1;
    exp_ppf = 32'h4;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("strm_ppf",   bus.ifetch_pc_plus_four, exp_ppf);
      chk("strm_instr", bus.ifetch_instruction, word(exp_ppf - 32'd4));
      exp_ppf += 32'd4;
      tick();
    end

    // redirect with 3 queued + 1 in flight
    bus.dispatch_ren = 1'b0;
    bus.dispatch_jump_branch = 1'b1;
    bus.dispatch_jmp_branch_addr = 32'h100;
    #1 chk("redir_rden", 32'(bus.imem_rd_en), 32'd0);
    tick(); bus.dispatch_jump_branch = 1'b0;
    #1;
    chk("redir_empty", 32'(bus.ifetch_empty_flag), 32'd1);
    chk("redir_instr", bus.ifetch_instruction, 32'h0);
    chk("redir_addr",  bus.imem_addr, 32'h100);
    chk("redir_rden1", 32'(bus.imem_rd_en), 32'd1);
    tick(); #1;
    chk("redir_empty2", 32'(bus.ifetch_empty_flag), 32'd1);
    chk("redir_addr2",  bus.imem_addr, 32'h104);
    tick(); #1;
    chk("redir_head",  bus.ifetch_instruction, word(32'h100));
    chk("redir_ppf",   bus.ifetch_pc_plus_four, 32'h104);

    // jump and pop in the same cycle: flush wins
    bus.dispatch_ren = 1'b1;
    bus.dispatch_jump_branch = 1'b1;
    bus.dispatch_jmp_branch_addr = 32'h200;
    #1 chk("jp_rden", 32'(bus.imem_rd_en), 32'd0);
    tick(); bus.dispatch_jump_branch = 1'b0;
    #1;
    chk("jp_empty", 32'(bus.ifetch_empty_flag), 32'd1);
    chk("jp_ppf",   bus.ifetch_pc_plus_four, 32'h0);
    chk("jp_addr",  bus.imem_addr, 32'h200);
    // pop while empty has no effect
    tick(); #1;
    chk("epop_empty", 32'(bus.ifetch_empty_flag), 32'd1);
    chk("epop_instr", bus.ifetch_instruction, 32'h0);
    chk("epop_ppf",   bus.ifetch_pc_plus_four, 32'h0);
    tick();
    // fill + pop each cycle: head starts at target, nothing lost or duplicated
    exp_ppf = 32'h204;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fp_ppf",   bus.ifetch_pc_plus_four, exp_ppf);
      chk("fp_instr", bus.ifetch_instruction, word(exp_ppf - 32'd4));
      exp_ppf += 32'd4;
      tick();
    end

    // build 2 entries at 0x300, then async reset mid-cycle
    bus.dispatch_ren = 1'b0;
    bus.dispatch_jump_branch = 1'b1;
    bus.dispatch_jmp_branch_addr = 32'h300;
    tick(); bus.dispatch_jump_branch = 1'b0;
    tick(); tick(); tick(); #1;
    chk("pre_rst_ppf", bus.ifetch_pc_plus_four, 32'h304);
    #1 rst = 1'b1;
    #1;
    chk("arst_empty", 32'(bus.ifetch_empty_flag), 32'd1);
    chk("arst_full",  32'(bus.ifetch_full_flag), 32'd0);
    chk("arst_instr", bus.ifetch_instruction, 32'h0);
    chk("arst_ppf",   bus.ifetch_pc_plus_four, 32'h0);
    chk("arst_rden",  32'(bus.imem_rd_en), 32'd0);
    tick(); rst = 1'b0;
    #1;
    chk("rel_rden", 32'(bus.imem_rd_en), 32'd1);
    chk("rel_addr", bus.imem_addr, 32'h0);
    tick(); #1;
`ifdef IFQ_BYPASS_EN
    chk("rel_byp_empty", 32'(bus.ifetch_empty_flag), 32'd0);
    chk("rel_byp_instr", bus.ifetch_instruction, 32'h00A0_0093);
`else
    chk("rel_empty", 32'(bus.ifetch_empty_flag), 32'd1);
    chk("rel_instr", bus.ifetch_instruction, 32'h0);
`endif
    tick(); #1;
    chk("rel_head", bus.ifetch_instruction, 32'h00A0_0093);
    chk("rel_ppf",  bus.ifetch_pc_plus_four, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
